// File: rtl/io_stimulus_player_if.sv
// Bus bundle for io_stimulus_player: schedule programming, playback pins and capture readback.
// The master side is the bench or debug host; the slave side is the player itself.
interface io_stimulus_player_if #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 16,
    parameter int DELAY_W = 16,
    parameter int IRQW    = 4
);
    localparam int AW = $clog2(DEPTH);

    logic               prog_we;
    logic [AW-1:0]      prog_addr;
    logic [DATA_W-1:0]  prog_value;
    logic [DELAY_W-1:0] prog_delay;
    logic [IRQW-1:0]    prog_irq_len;
    logic               prog_last;
    logic               start;
    logic               busy;
    logic               done;
    logic [DATA_W-1:0]  in_port;
    logic               interrupt;
    logic [DATA_W-1:0]  out_port;
    logic               log_rd;
    logic               log_valid;
    logic [DATA_W-1:0]  log_data;
    logic [DELAY_W-1:0] log_time;
    logic               log_overflow;

    modport master (
        output prog_we, prog_addr, prog_value, prog_delay, prog_irq_len, prog_last,
        output start, out_port, log_rd,
        input  busy, done, in_port, interrupt,
        input  log_valid, log_data, log_time, log_overflow
    );

    modport slave (
        input  prog_we, prog_addr, prog_value, prog_delay, prog_irq_len, prog_last,
        input  start, out_port, log_rd,
        output busy, done, in_port, interrupt,
        output log_valid, log_data, log_time, log_overflow
    );
endinterface

// File: rtl/io_stimulus_player.sv
// Table-driven stimulus player: replays in_port values and interrupt pulses at programmed offsets.
// Define STIM_LOG_EN to build the timestamped out_port capture FIFO; otherwise the log outputs are tied to 0.
module io_stimulus_player #(
    parameter int DATA_W    = 16,
    parameter int DEPTH     = 16,
    parameter int DELAY_W   = 16,
    parameter int IRQW      = 4,
    parameter int LOG_DEPTH = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    io_stimulus_player_if.slave     bus,
    output logic [1:0]              o_dbg_state
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_PTR = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_WAIT  = 2'd1,
        S_APPLY = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic               w_start_acc;
    logic               w_apply;
    logic               w_finish;
    logic [AW-1:0]      w_ptr_inc;

    logic [AW-1:0]      r_ptr;
    logic [DELAY_W-1:0] r_cnt;
    logic               r_busy;
    logic               r_done;
    logic [DATA_W-1:0]  r_in_port;
    logic               r_irq;
    logic [IRQW-1:0]    r_irq_cnt;

    logic [DATA_W-1:0]  r_mem_value [DEPTH];
    logic [DELAY_W-1:0] r_mem_delay [DEPTH];
    logic [IRQW-1:0]    r_mem_irq   [DEPTH];
    logic               r_mem_last  [DEPTH];

    assign w_ptr_inc = r_ptr + 1'b1;

    always_comb begin
        w_state_next = r_state;
        w_start_acc  = 1'b0;
        w_apply      = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_start_acc  = 1'b1;
                    w_state_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == '0) w_state_next = S_APPLY;
            end
            S_APPLY: begin
                w_apply = 1'b1;
                // The pointer never wraps: the final slot ends playback even without a last mark.
                if (r_mem_last[r_ptr] || (r_ptr == LAST_PTR)) begin
                    w_finish     = 1'b1;
                    w_state_next = S_IDLE;
                end else begin
                    w_state_next = S_WAIT;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_in_port <= '0;
            r_irq     <= 1'b0;
            r_irq_cnt <= '0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_finish;
            if (w_start_acc) begin
                r_busy <= 1'b1;
                r_ptr  <= '0;
                r_cnt  <= r_mem_delay[0];
            end else if ((r_state == S_WAIT) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_apply) begin
                r_in_port <= r_mem_value[r_ptr];
                if (w_finish) begin
                    r_busy <= 1'b0;
                end else begin
                    r_ptr <= w_ptr_inc;
                    r_cnt <= r_mem_delay[w_ptr_inc];
                end
            end
            // A new pulse restarts the length counter, so overlapping pulses merge without a gap.
            if (w_apply && (r_mem_irq[r_ptr] != '0)) begin
                r_irq     <= 1'b1;
                r_irq_cnt <= r_mem_irq[r_ptr];
            end else if (r_irq_cnt != '0) begin
                r_irq_cnt <= r_irq_cnt - 1'b1;
                r_irq     <= (r_irq_cnt != IRQW'(1));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (bus.prog_we && (r_state == S_IDLE)) begin
            r_mem_value[bus.prog_addr] <= bus.prog_value;
            r_mem_delay[bus.prog_addr] <= bus.prog_delay;
            r_mem_irq[bus.prog_addr]   <= bus.prog_irq_len;
            r_mem_last[bus.prog_addr]  <= bus.prog_last;
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.in_port   = r_in_port;
    assign bus.interrupt = r_irq;
    assign o_dbg_state   = r_state;

`ifdef STIM_LOG_EN
    localparam int LAW = $clog2(LOG_DEPTH);

    logic [DATA_W-1:0]  r_log_data [LOG_DEPTH];
    logic [DELAY_W-1:0] r_log_time [LOG_DEPTH];
    logic [LAW-1:0]     r_wptr;
    logic [LAW-1:0]     r_rptr;
    logic [LAW:0]       r_count;
    logic [DELAY_W-1:0] r_ts;
    logic [DATA_W-1:0]  r_prev_out;
    logic               r_cap_vld;
    logic [DATA_W-1:0]  r_cap_data;
    logic [DELAY_W-1:0] r_cap_time;
    logic               r_ovf;
    logic               w_log_run;
    logic               w_full;
    logic               w_empty;
    logic               w_pop;
    logic               w_push_ok;

    assign w_log_run = reset && !w_start_acc;
    assign w_full    = (r_count == (LAW + 1)'(LOG_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_pop     = w_log_run && bus.log_rd && !w_empty;
    // A full FIFO still accepts a push when the head is popped in the same cycle.
    assign w_push_ok = w_log_run && r_cap_vld && (!w_full || w_pop);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ts       <= '0;
            r_prev_out <= '0;
            r_cap_vld  <= 1'b0;
            r_cap_data <= '0;
            r_cap_time <= '0;
            r_ovf      <= 1'b0;
        end else if (w_start_acc) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_ts       <= '0;
            r_prev_out <= bus.out_port;
            r_cap_vld  <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (r_ts != '1) r_ts <= r_ts + 1'b1;
            r_prev_out <= bus.out_port;
            r_cap_vld  <= (r_busy || r_irq) && (bus.out_port != r_prev_out);
            r_cap_data <= bus.out_port;
            r_cap_time <= r_ts;
            if (w_pop) r_rptr <= r_rptr + 1'b1;
            if (w_push_ok) r_wptr <= r_wptr + 1'b1;
            if (r_cap_vld && !w_push_ok) r_ovf <= 1'b1;
            case ({w_push_ok, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_log_data[r_wptr] <= r_cap_data;
            r_log_time[r_wptr] <= r_cap_time;
        end
    end

    assign bus.log_valid    = !w_empty;
    assign bus.log_data     = w_empty ? '0 : r_log_data[r_rptr];
    assign bus.log_time     = w_empty ? '0 : r_log_time[r_rptr];
    assign bus.log_overflow = r_ovf;
`else
    logic w_unused;
    assign w_unused = ^{bus.out_port, bus.log_rd, LOG_DEPTH[0]};

    assign bus.log_valid    = 1'b0;
    assign bus.log_data     = '0;
    assign bus.log_time     = '0;
    assign bus.log_overflow = 1'b0;
`endif
endmodule

// File: tb/tb_io_stimulus_player.sv
// Bench for io_stimulus_player: a schedule model predicts apply cycles, interrupt windows and captures.
`timescale 1ns/1ps
module tb_io_stimulus_player;
    localparam int DATA_W    = 16;
    localparam int DEPTH     = 8;
    localparam int DELAY_W   = 16;
    localparam int IRQW      = 4;
    localparam int LOG_DEPTH = 8;
    localparam int AW        = $clog2(DEPTH);

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] dbg_state;
    int         cyc = 0;
    int         n_checks = 0;
    int         n_fail = 0;

    // Reference copy of the slot table as the bench programmed it.
    logic [DATA_W-1:0] m_value [DEPTH];
    int                m_delay [DEPTH];
    int                m_irq   [DEPTH];
    bit                m_last  [DEPTH];
    logic [DATA_W-1:0] last_in = '0;

    logic [DATA_W-1:0]  exp_q[$];
    int                 exp_cyc_q[$];
    int                 exp_irq_q[$];
    logic [DELAY_W-1:0] exp_t_q[$];

    io_stimulus_player_if #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DELAY_W(DELAY_W), .IRQW(IRQW)) bus();

    io_stimulus_player #(
        .DATA_W(DATA_W), .DEPTH(DEPTH), .DELAY_W(DELAY_W), .IRQW(IRQW), .LOG_DEPTH(LOG_DEPTH)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic idle_inputs();
        bus.prog_we      = 1'b0;
        bus.prog_addr    = '0;
        bus.prog_value   = '0;
        bus.prog_delay   = '0;
        bus.prog_irq_len = '0;
        bus.prog_last    = 1'b0;
        bus.start        = 1'b0;
        bus.log_rd       = 1'b0;
    endtask

    task automatic program_slot(input int a, input logic [DATA_W-1:0] v, input int d,
                                input int irq, input bit last);
        @(negedge clk);
        bus.prog_we      = 1'b1;
        bus.prog_addr    = AW'(a);
        bus.prog_value   = v;
        bus.prog_delay   = DELAY_W'(d);
        bus.prog_irq_len = IRQW'(irq);
        bus.prog_last    = last;
        m_value[a] = v;
        m_delay[a] = d;
        m_irq[a]   = irq;
        m_last[a]  = last;
        @(negedge clk);
        bus.prog_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.interrupt, bus.log_valid, bus.log_overflow} !== 5'b0) begin
            n_fail++;
            $display("FAIL reset_flags got=%b exp=00000",
                     {bus.busy, bus.done, bus.interrupt, bus.log_valid, bus.log_overflow});
        end
        n_checks++;
        if ({bus.in_port, bus.log_data, bus.log_time} !== '0) begin
            n_fail++;
            $display("FAIL reset_data in_port=%h log_data=%h log_time=%h exp=0",
                     bus.in_port, bus.log_data, bus.log_time);
        end
        n_checks++;
        if (dbg_state !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_state got=%0d exp=0", dbg_state);
        end
        reset = 1'b1;
        last_in = '0;
    endtask

    // Starts playback and checks in_port, interrupt, busy and done every cycle against the table model.
    // With inject set, start and prog_we are hammered for as long as the player is busy.
    task automatic run_playback(input bit inject, output int irq_hi);
        int t, a, done_cyc, irq_end, irq_fin, stop, l;
        logic [DATA_W-1:0] exp_in;
        logic [AW-1:0] ia;
        @(negedge clk);
        bus.start = 1'b1;
        t = cyc + 1;
        a = t;
        irq_fin = 0;
        for (int k = 0; k < DEPTH; k++) begin
            a = a + m_delay[k] + 2;
            exp_q.push_back(m_value[k]);
            exp_cyc_q.push_back(a);
            exp_irq_q.push_back(m_irq[k]);
            if (m_irq[k] > 0) irq_fin = a + m_irq[k];
            if (m_last[k] || k == DEPTH - 1) break;
        end
        done_cyc = a;
        stop = ((irq_fin > done_cyc) ? irq_fin : done_cyc) + 2;
        exp_in = last_in;
        irq_end = 0;
        irq_hi = 0;
        while (cyc < stop) begin
            @(negedge clk);
            if (exp_cyc_q.size() > 0 && exp_cyc_q[0] == cyc) begin
                exp_in = exp_q.pop_front();
                void'(exp_cyc_q.pop_front());
                l = exp_irq_q.pop_front();
                if (l > 0) irq_end = cyc + l;
            end
            n_checks++;
            if (bus.in_port !== exp_in) begin
                n_fail++;
                $display("FAIL in_port cyc=%0d got=%h exp=%h", cyc - t, bus.in_port, exp_in);
            end
            n_checks++;
            if (bus.interrupt !== (cyc < irq_end)) begin
                n_fail++;
                $display("FAIL interrupt cyc=%0d got=%b exp=%b", cyc - t, bus.interrupt, cyc < irq_end);
            end
            n_checks++;
            if (bus.busy !== (cyc < done_cyc)) begin
                n_fail++;
                $display("FAIL busy cyc=%0d got=%b exp=%b", cyc - t, bus.busy, cyc < done_cyc);
            end
            n_checks++;
            if (bus.done !== (cyc == done_cyc)) begin
                n_fail++;
                $display("FAIL done cyc=%0d got=%b exp=%b", cyc - t, bus.done, cyc == done_cyc);
            end
            if (bus.interrupt === 1'b1) irq_hi++;
            if (inject && cyc < done_cyc) begin
                ia = AW'($urandom_range(0, DEPTH - 1));
                bus.start        = 1'b1;
                bus.prog_we      = 1'b1;
                bus.prog_addr    = ia;
                bus.prog_value   = ~m_value[ia];
                bus.prog_delay   = '0;
                bus.prog_irq_len = IRQW'(1);
                bus.prog_last    = 1'b1;
            end else begin
                idle_inputs();
            end
        end
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL events_missing got=%0d left exp=0", exp_q.size());
            exp_q.delete();
            exp_cyc_q.delete();
            exp_irq_q.delete();
        end
        last_in = exp_in;
    endtask

    task automatic test_basic_schedule();
        int hi;
        program_slot(0, 16'h0300, 200, 0, 1'b0);
        program_slot(1, 16'h0040, 0, 0, 1'b0);
        program_slot(2, 16'h0500, 0, 0, 1'b0);
        program_slot(3, 16'h0100, 0, 0, 1'b0);
        program_slot(4, 16'h07FE, 13, 0, 1'b1);
        run_playback(1'b0, hi);
        n_checks++;
        if (hi != 0) begin
            n_fail++;
            $display("FAIL basic_no_irq got=%0d exp=0", hi);
        end
    endtask

    task automatic test_irq_merge();
        int hi;
        program_slot(0, 16'h0300, 4, 0, 1'b0);
        program_slot(1, 16'h0040, 0, 3, 1'b0);
        program_slot(2, 16'h0500, 0, 5, 1'b0);
        run_playback(1'b0, hi);
        n_checks++;
        if (hi != 7) begin
            n_fail++;
            $display("FAIL irq_merge_len got=%0d exp=7", hi);
        end
    endtask

    task automatic test_no_last();
        int hi;
        for (int k = 0; k < DEPTH; k++)
            program_slot(k, DATA_W'($urandom_range(1, 16'hFFFF)), $urandom_range(0, 5),
                         (k == 6) ? 2 : 0, 1'b0);
        run_playback(1'b0, hi);
        n_checks++;
        if (hi != 2) begin
            n_fail++;
            $display("FAIL no_last_irq got=%0d exp=2", hi);
        end
    endtask

    task automatic test_reset_mid_wait();
        int hi;
        program_slot(0, 16'hA5A5, 40, 0, 1'b0);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        n_checks++;
        if (dbg_state !== 2'd1 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_wait state=%0d busy=%b exp state=1 busy=1", dbg_state, bus.busy);
        end
        reset = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus.busy, bus.done, bus.interrupt, bus.in_port, dbg_state} !== '0) begin
            n_fail++;
            $display("FAIL abort_outputs busy=%b done=%b irq=%b in_port=%h state=%0d exp all 0",
                     bus.busy, bus.done, bus.interrupt, bus.in_port, dbg_state);
        end
        reset = 1'b1;
        last_in = '0;
        repeat (4) begin
            @(negedge clk);
            n_checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                n_fail++;
                $display("FAIL abort_no_done done=%b busy=%b exp 0 0", bus.done, bus.busy);
            end
        end
        run_playback(1'b0, hi);
    endtask

    task automatic test_busy_ignore();
        int hi;
        run_playback(1'b1, hi);
        run_playback(1'b0, hi);
    endtask

`ifdef STIM_LOG_EN
    task automatic test_log_overflow();
        int t, n, wait_cyc;
        logic [DELAY_W-1:0] prev_t;
        logic [DELAY_W-1:0] et;
        logic [DATA_W-1:0]  ed;
        program_slot(0, 16'h0042, 100, 0, 1'b1);
        bus.out_port = '0;
        @(negedge clk);
        bus.start = 1'b1;
        t = cyc + 1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 9; i++) begin
            n = cyc;
            bus.out_port = DATA_W'(16'h1000 + i + 1);
            if (exp_q.size() < LOG_DEPTH) begin
                exp_q.push_back(bus.out_port);
                exp_t_q.push_back(DELAY_W'(n - t));
            end
            repeat (2) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        n_checks++;
        if (bus.log_overflow !== 1'b1 || bus.log_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL log_overflow ovf=%b valid=%b exp 1 1", bus.log_overflow, bus.log_valid);
        end
        prev_t = '0;
        for (int i = 0; i < LOG_DEPTH; i++) begin
            ed = exp_q.pop_front();
            et = exp_t_q.pop_front();
            n_checks++;
            if (bus.log_valid !== 1'b1 || bus.log_data !== ed || bus.log_time !== et) begin
                n_fail++;
                $display("FAIL log_entry%0d valid=%b data=%h time=%0d exp 1 %h %0d",
                         i, bus.log_valid, bus.log_data, bus.log_time, ed, et);
            end
            n_checks++;
            if (i > 0 && !(bus.log_time > prev_t)) begin
                n_fail++;
                $display("FAIL log_order%0d got=%0d exp>%0d", i, bus.log_time, prev_t);
            end
            prev_t = bus.log_time;
            bus.log_rd = 1'b1;
            @(negedge clk);
        end
        bus.log_rd = 1'b0;
        n_checks++;
        if (bus.log_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL log_drained got=%b exp=0", bus.log_valid);
        end
        wait_cyc = 0;
        while (bus.busy === 1'b1 && wait_cyc < 300) begin
            @(negedge clk);
            wait_cyc++;
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.in_port !== 16'h0042) begin
            n_fail++;
            $display("FAIL log_play_end busy=%b in_port=%h exp 0 0042", bus.busy, bus.in_port);
        end
        last_in = 16'h0042;
    endtask
`else
    task automatic test_log_disabled();
        int wait_cyc;
        program_slot(0, 16'h0042, 30, 0, 1'b1);
        bus.out_port = '0;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.out_port = DATA_W'($urandom_range(1, 16'hFFFF));
            bus.log_rd = 1'(i % 2);
            @(negedge clk);
            n_checks++;
            if ({bus.log_valid, bus.log_overflow, bus.log_data, bus.log_time} !== '0) begin
                n_fail++;
                $display("FAIL log_tied valid=%b ovf=%b data=%h time=%h exp all 0",
                         bus.log_valid, bus.log_overflow, bus.log_data, bus.log_time);
            end
        end
        bus.log_rd = 1'b0;
        wait_cyc = 0;
        while (bus.busy === 1'b1 && wait_cyc < 300) begin
            @(negedge clk);
            wait_cyc++;
        end
        n_checks++;
        if (bus.busy !== 1'b0 || bus.in_port !== 16'h0042) begin
            n_fail++;
            $display("FAIL log_play_end busy=%b in_port=%h exp 0 0042", bus.busy, bus.in_port);
        end
        last_in = 16'h0042;
    endtask
`endif

    initial begin
        idle_inputs();
        bus.out_port = '0;
        test_reset();
        test_basic_schedule();
        test_irq_merge();
        test_no_last();
        test_reset_mid_wait();
        test_busy_ignore();
`ifdef STIM_LOG_EN
        test_log_overflow();
`else
        test_log_disabled();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
